// File: rtl/lpu_ctrl_pkg.sv
// Shared control types and encodings for the LEGv8 control blocks.
// Used by both the multi-cycle sequencer and the opcode decoder.
package lpu_ctrl_pkg;

    localparam int unsigned OP_W     = 11;
    localparam int unsigned ALUOP_W  = 4;
    localparam int unsigned SIGNOP_W = 3;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_LDUR  = 3'd1,
        CLS_STUR  = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_CBZ   = 3'd4,
        CLS_B     = 3'd5,
        CLS_MOVZ  = 3'd6
    } op_class_t;

    // Opcode patterns; bits cleared in the mask are immediate/register fields
    localparam logic [OP_W-1:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [OP_W-1:0] OPC_STUR  = 11'b11111000000;
    localparam logic [OP_W-1:0] OPC_ADD   = 11'b10001011000;
    localparam logic [OP_W-1:0] OPC_SUB   = 11'b11001011000;
    localparam logic [OP_W-1:0] OPC_AND   = 11'b10001010000;
    localparam logic [OP_W-1:0] OPC_ORR   = 11'b10101010000;
    localparam logic [OP_W-1:0] OPC_CBZ   = 11'b10110100000;
    localparam logic [OP_W-1:0] OPC_B     = 11'b00010100000;
    localparam logic [OP_W-1:0] OPC_MOVZ  = 11'b11010010100;

    localparam logic [OP_W-1:0] MASK_FULL = 11'b11111111111;
    localparam logic [OP_W-1:0] MASK_CBZ  = 11'b11111111000;
    localparam logic [OP_W-1:0] MASK_B    = 11'b11111100000;
    localparam logic [OP_W-1:0] MASK_MOVZ = 11'b11111111100;

    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALUOP_ORR  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_MOVZ = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'b0111;

    localparam logic [SIGNOP_W-1:0] SIGNOP_NONE = 3'b000;
    localparam logic [SIGNOP_W-1:0] SIGNOP_D    = 3'b001;
    localparam logic [SIGNOP_W-1:0] SIGNOP_B    = 3'b010;
    localparam logic [SIGNOP_W-1:0] SIGNOP_CBZ  = 3'b011;
    localparam logic [SIGNOP_W-1:0] SIGNOP_MOVZ = 3'b100;

    typedef struct packed {
        op_class_t           cls;
        logic [ALUOP_W-1:0]  aluop;
        logic [SIGNOP_W-1:0] signop;
        logic                reg2loc;
        logic                alusrc;
        logic                mem2reg;
        logic                legal;
    } ctrl_dec_t;

    function automatic logic op_match(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] pat,
                                      input logic [OP_W-1:0] mask);
        return (op & mask) == (pat & mask);
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational LEGv8 opcode decoder: instruction class plus datapath selects.
// Shared between the single-cycle and multi-cycle control paths.
module opcode_decoder
    import lpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output ctrl_dec_t       dec_c
);

    always_comb begin
        dec_c.cls     = CLS_NONE;
        dec_c.aluop   = ALUOP_AND;
        dec_c.signop  = SIGNOP_NONE;
        dec_c.reg2loc = 1'b0;
        dec_c.alusrc  = 1'b0;
        dec_c.mem2reg = 1'b0;
        dec_c.legal   = 1'b0;

        if (op_match(opcode, OPC_LDUR, MASK_FULL)) begin
            dec_c.cls     = CLS_LDUR;
            dec_c.aluop   = ALUOP_ADD;
            dec_c.signop  = SIGNOP_D;
            dec_c.alusrc  = 1'b1;
            dec_c.mem2reg = 1'b1;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_STUR, MASK_FULL)) begin
            dec_c.cls     = CLS_STUR;
            dec_c.aluop   = ALUOP_ADD;
            dec_c.signop  = SIGNOP_D;
            dec_c.reg2loc = 1'b1;
            dec_c.alusrc  = 1'b1;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_ADD, MASK_FULL)) begin
            dec_c.cls     = CLS_RTYPE;
            dec_c.aluop   = ALUOP_ADD;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_SUB, MASK_FULL)) begin
            dec_c.cls     = CLS_RTYPE;
            dec_c.aluop   = ALUOP_SUB;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_AND, MASK_FULL)) begin
            dec_c.cls     = CLS_RTYPE;
            dec_c.aluop   = ALUOP_AND;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_ORR, MASK_FULL)) begin
            dec_c.cls     = CLS_RTYPE;
            dec_c.aluop   = ALUOP_ORR;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_CBZ, MASK_CBZ)) begin
            dec_c.cls     = CLS_CBZ;
            dec_c.aluop   = ALUOP_SUB;
            dec_c.signop  = SIGNOP_CBZ;
            dec_c.reg2loc = 1'b1;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_B, MASK_B)) begin
            dec_c.cls     = CLS_B;
            dec_c.signop  = SIGNOP_B;
            dec_c.legal   = 1'b1;
        end else if (op_match(opcode, OPC_MOVZ, MASK_MOVZ)) begin
            dec_c.cls     = CLS_MOVZ;
            dec_c.aluop   = ALUOP_MOVZ;
            dec_c.signop  = SIGNOP_MOVZ;
            dec_c.alusrc  = 1'b1;
            dec_c.legal   = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// arbitrates the shared memory port with a bounded req/ready handshake.
module multicycle_control
    import lpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic                run,
    input  logic [OP_W-1:0]     opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [SIGNOP_W-1:0] signop,
    output logic [STATE_W-1:0]  state,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire, stall, drive_dec;
    ctrl_dec_t        dec_c;

    // IR holds the opcode stable from DECODE until the next fetch completes
    opcode_decoder u_dec (
        .opcode (opcode),
        .dec_c  (dec_c)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        retire    = 1'b0;
        stall     = 1'b0;
        drive_dec = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg2loc   = 1'b0;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        regwrite  = 1'b0;
        aluop     = '0;
        signop    = '0;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_DECODE: begin
                drive_dec = 1'b1;
                state_d   = dec_c.legal ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                drive_dec = 1'b1;
                case (dec_c.cls)
                    CLS_RTYPE, CLS_MOVZ: state_d = ST_WB;
                    CLS_LDUR, CLS_STUR:  state_d = ST_MEM;
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    CLS_CBZ: begin
                        pc_write = zero;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                drive_dec = 1'b1;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (dec_c.cls == CLS_STUR);
                if (mem_ready) begin
                    if (dec_c.cls == CLS_STUR) retire = 1'b1;
                    else                       state_d = ST_WB;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_WB: begin
                drive_dec = 1'b1;
                regwrite  = 1'b1;
                retire    = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_HALT;
        endcase

        if (retire) state_d = run ? ST_FETCH : ST_IDLE;

        // Ready on the terminal-count edge completes normally; only a stall faults
        if (stall) begin
            if (tmo_cnt_q == TMO_LAST) state_d = ST_HALT;
            else                       tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        if (drive_dec) begin
            aluop   = dec_c.aluop;
            signop  = dec_c.signop;
            reg2loc = dec_c.reg2loc;
            alusrc  = dec_c.alusrc;
            mem2reg = dec_c.mem2reg;
        end

        retired_d = retired_q + CNT_W'(retire);
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control with a variable-latency memory.
module tb_multicycle_control;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned TMO    = 255;
    localparam int          N_RAND = 40;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    logic             CLK = 1'b0;
    logic             resetl, run, zero, mem_ready;
    logic [10:0]      opcode;
    logic             mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic             reg2loc, alusrc, mem2reg, regwrite, halted;
    logic [3:0]       aluop;
    logic [2:0]       signop, state;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .resetl(resetl), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
        .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite), .aluop(aluop),
        .signop(signop), .state(state), .halted(halted), .retired(retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] op;
        bit          z;
        int          flat;
        int          mlat;
    } instr_t;

    typedef struct {
        bit         legal;
        int         idx;
        int         cyc;
        int         nf;
        int         nw;
        int         nr;
        int         nbr;
        int         npc;
        int         nrw;
        bit         m2r;
        logic [3:0] aluop;
        logic [2:0] signop;
        bit         r2l;
        bit         asrc;
    } exp_t;

    instr_t prog[$];
    exp_t   sb[$];
    int     n_pass = 0;
    int     n_chk  = 0;
    bit     pause_en = 1'b0;
    int     fetch_idx = 0;
    logic   s_req = 1'b0, s_ready = 1'b0, s_asel = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic instr_t mk(input logic [10:0] op, input bit z, input int f, input int m);
        instr_t i;
        i.op = op; i.z = z; i.flat = f; i.mlat = m;
        return i;
    endfunction

    // Expected per-instruction behaviour derived from the opcode table
    function automatic exp_t model(input instr_t i, input int idx);
        exp_t e;
        bit ld, st, rt, cbz, br, mz;
        ld  = (i.op == OP_LDUR);
        st  = (i.op == OP_STUR);
        rt  = (i.op == OP_ADD) || (i.op == OP_SUB) || (i.op == OP_AND) || (i.op == OP_ORR);
        cbz = (i.op[10:3] == 8'b10110100);
        br  = (i.op[10:5] == 6'b000101);
        mz  = (i.op[10:2] == 9'b110100101);
        e.legal = ld || st || rt || cbz || br || mz;
        e.idx   = idx;
        e.nf    = 1;
        e.npc   = 1;
        e.nw    = st ? 1 : 0;
        e.nr    = ld ? 1 : 0;
        e.nrw   = (rt || ld || mz) ? 1 : 0;
        e.m2r   = ld;
        e.nbr   = (br || (cbz && i.z)) ? 1 : 0;
        e.cyc   = (i.flat + 1) + 1 + 1 + ((ld || st) ? i.mlat + 1 : 0) + e.nrw;
        if (i.op == OP_AND)                     e.aluop = 4'b0000;
        else if (i.op == OP_ORR)                e.aluop = 4'b0001;
        else if (i.op == OP_ADD || ld || st)    e.aluop = 4'b0010;
        else if (i.op == OP_SUB || cbz)         e.aluop = 4'b0111;
        else if (mz)                            e.aluop = 4'b0110;
        else                                    e.aluop = 4'b0000;
        if (ld || st)    e.signop = 3'b001;
        else if (br)     e.signop = 3'b010;
        else if (cbz)    e.signop = 3'b011;
        else if (mz)     e.signop = 3'b100;
        else             e.signop = 3'b000;
        e.r2l  = st || cbz;
        e.asrc = ld || st || mz;
        return e;
    endfunction

    function automatic logic [10:0] rand_op();
        logic [10:0] r;
        r = 11'($urandom);
        case ($urandom_range(0, 8))
            0:       return OP_LDUR;
            1:       return OP_STUR;
            2:       return OP_ADD;
            3:       return OP_SUB;
            4:       return OP_AND;
            5:       return OP_ORR;
            6:       return {8'b10110100, r[2:0]};
            7:       return {6'b000101, r[4:0]};
            default: return {9'b110100101, r[1:0]};
        endcase
    endfunction

    // Memory / IR driver: variable-latency responder that issues the program
    initial begin
        int   cur_idx, stall, lat, pause_cnt;
        bit   busy, pause;
        exp_t e;
        mem_ready = 1'b0; opcode = '0; zero = 1'b0; run = 1'b0;
        cur_idx = 0; stall = 0; lat = 0; pause_cnt = 0; busy = 1'b0; pause = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!resetl) begin
                busy = 1'b0; mem_ready = 1'b0; fetch_idx = 0; pause = 1'b0; stall = 0;
                run = (prog.size() > 0);
            end else begin
                if (s_req && s_ready) begin
                    if (!s_asel && fetch_idx < prog.size()) begin
                        opcode  = prog[fetch_idx].op;
                        zero    = prog[fetch_idx].z;
                        cur_idx = fetch_idx;
                        e = model(prog[fetch_idx], fetch_idx + 1);
                        if (e.legal) sb.push_back(e);
                        fetch_idx++;
                        if (pause_en && $urandom_range(0, 7) == 0) begin
                            pause = 1'b1;
                            pause_cnt = int'($urandom_range(1, 4));
                        end
                    end
                    busy = 1'b0;
                    mem_ready = 1'b0;
                end
                if (pause && state == 3'd0) begin
                    pause_cnt--;
                    if (pause_cnt <= 0) pause = 1'b0;
                end
                run = (fetch_idx < prog.size()) && !pause;
                if (mem_req && !busy) begin
                    busy = 1'b1;
                    stall = 0;
                    if (addr_sel)                    lat = prog[cur_idx].mlat;
                    else if (fetch_idx < prog.size()) lat = prog[fetch_idx].flat;
                    else                             lat = 0;
                end
                if (busy) begin
                    mem_ready = (stall == lat);
                    stall++;
                end
            end
        end
    end

    // Monitor: summarises each instruction and checks it when retired advances
    initial begin
        int   cyc, nf, nw, nr, nbr, npc, nrw;
        bit   m2r, r2l, asrc;
        logic [3:0] c_alu;
        logic [2:0] c_sop;
        logic [CNT_W-1:0] prev;
        exp_t e;
        cyc = 0; nf = 0; nw = 0; nr = 0; nbr = 0; npc = 0; nrw = 0;
        m2r = 0; r2l = 0; asrc = 0; c_alu = '0; c_sop = '0; prev = '0;
        forever begin
            @(negedge CLK);
            s_req = mem_req; s_ready = mem_ready; s_asel = addr_sel;
            if (!resetl) begin
                prev = '0; sb.delete();
                cyc = 0; nf = 0; nw = 0; nr = 0; nbr = 0; npc = 0; nrw = 0;
                m2r = 0; r2l = 0; asrc = 0; c_alu = '0; c_sop = '0;
                continue;
            end
            if (retired != prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 64'(retired), 64'(prev));
                end else begin
                    e = sb.pop_front();
                    chk("retired",   64'(retired), 64'(e.idx));
                    chk("cycles",    64'(cyc),     64'(e.cyc));
                    chk("fetches",   64'(nf),      64'(e.nf));
                    chk("mem_write", 64'(nw),      64'(e.nw));
                    chk("mem_read",  64'(nr),      64'(e.nr));
                    chk("branch_pc", 64'(nbr),     64'(e.nbr));
                    chk("pc_plus4",  64'(npc),     64'(e.npc));
                    chk("regwrite",  64'(nrw),     64'(e.nrw));
                    chk("mem2reg",   64'(m2r),     64'(e.m2r));
                    chk("aluop",     64'(c_alu),   64'(e.aluop));
                    chk("signop",    64'(c_sop),   64'(e.signop));
                    chk("reg2loc",   64'(r2l),     64'(e.r2l));
                    chk("alusrc",    64'(asrc),    64'(e.asrc));
                end
                prev = retired;
                cyc = 0; nf = 0; nw = 0; nr = 0; nbr = 0; npc = 0; nrw = 0;
                m2r = 0; r2l = 0; asrc = 0; c_alu = '0; c_sop = '0;
            end
            if (state != 3'd0 && state != 3'd6) cyc++;
            if (mem_req && mem_ready) begin
                if (!addr_sel && ir_write) nf++;
                else if (addr_sel && mem_we) nw++;
                else if (addr_sel)           nr++;
            end
            if (pc_write) begin
                if (pc_src) nbr++;
                else        npc++;
            end
            if (regwrite) begin
                nrw++;
                m2r = mem2reg;
            end
            if (state == 3'd3) begin
                c_alu = aluop; c_sop = signop; r2l = reg2loc; asrc = alusrc;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time %0t exceeded limit 3000000", $time);
        $fatal(1);
    end

    task automatic do_reset();
        resetl = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #2 resetl = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string nm);
        for (int k = 0; k < maxc; k++) begin
            if (state == s) break;
            @(negedge CLK);
        end
        chk(nm, 64'(state), 64'(s));
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state == s && n < 1000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!(fetch_idx == prog.size() && state == 3'd0) && k < 20000) begin
            @(negedge CLK);
            k++;
        end
        chk(nm, 64'({fetch_idx == prog.size(), state}), 64'({1'b1, 3'd0}));
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int n;
        logic [10:0] bad_ops[2];
        resetl = 1'b0;

        // Reset with run high, then a 4-cycle fetch of ADD
        prog.delete();
        prog.push_back(mk(OP_ADD, 1'b0, 3, 0));
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 64'({mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                                  reg2loc, alusrc, mem2reg, regwrite, aluop, signop,
                                  state, halted, retired}), 64'd0);
        release_reset();
        wait_state(3'd1, 10, "enter_fetch");
        count_state(3'd1, n);
        chk("fetch_len", 64'(n), 64'd4);
        chk("after_fetch", 64'(state), 64'd2);
        wait_done("add_done");
        chk("add_retired", 64'(retired), 64'd1);

        // Randomized program with random latencies and run pauses
        do_reset();
        prog.delete();
        prog.push_back(mk(OP_LDUR, 1'b0, 1, 2));
        prog.push_back(mk(OP_STUR, 1'b0, 0, 1));
        for (int i = 0; i < N_RAND - 2; i++)
            prog.push_back(mk(rand_op(), 1'($urandom), int'($urandom_range(0, 4)),
                              int'($urandom_range(0, 4))));
        pause_en = 1'b1;
        release_reset();
        wait_done("rand_done");
        pause_en = 1'b0;
        chk("rand_retired", 64'(retired), 64'(N_RAND));
        chk("rand_sb_drained", 64'(sb.size()), 64'd0);
        chk("rand_no_halt", 64'(halted), 64'd0);

        // Illegal opcodes fault into HALT
        bad_ops[0] = 11'b00000000000;
        bad_ops[1] = 11'b11111000011;
        for (int b = 0; b < 2; b++) begin
            do_reset();
            prog.delete();
            prog.push_back(mk(bad_ops[b], 1'b0, 1, 0));
            release_reset();
            wait_state(3'd6, 30, "illegal_halt_state");
            chk("illegal_halted", 64'(halted), 64'd1);
            repeat (5) @(negedge CLK);
            chk("halt_sticky", 64'({state, mem_req, pc_write, regwrite}), 64'({3'd6, 3'b000}));
            chk("halt_retired", 64'(retired), 64'd0);
        end

        // Fetch stalled beyond the timeout
        do_reset();
        prog.delete();
        prog.push_back(mk(OP_ADD, 1'b0, 1000, 0));
        release_reset();
        wait_state(3'd1, 10, "tmo_enter_fetch");
        count_state(3'd1, n);
        chk("tmo_fetch_len", 64'(n), 64'(TMO));
        chk("tmo_state", 64'(state), 64'd6);
        chk("tmo_halted", 64'(halted), 64'd1);
        chk("tmo_mem_req", 64'(mem_req), 64'd0);

        // Ready on the terminal-count cycle completes without fault
        do_reset();
        prog.delete();
        prog.push_back(mk(OP_ADD, 1'b0, TMO - 1, 0));
        release_reset();
        wait_state(3'd1, 10, "edge_enter_fetch");
        count_state(3'd1, n);
        chk("edge_fetch_len", 64'(n), 64'(TMO));
        chk("edge_state", 64'(state), 64'd2);
        wait_done("edge_done");
        chk("edge_no_halt", 64'({halted, retired}), 64'({1'b0, 32'd1}));

        // Asynchronous reset in the middle of a data access
        do_reset();
        prog.delete();
        prog.push_back(mk(OP_ADD, 1'b0, 1, 0));
        prog.push_back(mk(OP_LDUR, 1'b0, 0, 20));
        release_reset();
        wait_state(3'd4, 60, "ldur_in_mem");
        chk("mem_access", 64'({mem_req, addr_sel, mem_we, retired}), 64'({3'b110, 32'd1}));
        @(posedge CLK);
        #3 resetl = 1'b0;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_retired", 64'(retired), 64'd0);
        repeat (2) @(negedge CLK);
        chk("async_hold", 64'({state, mem_req, halted}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
